divider_arbiter: RTL and testbench

//  Shares one iterative divider between NUM_REQ requesters (x/y centroid channels per tracked object).

---
 rtl/divider_arbiter.sv | 166 ++++++++++++++++
 tb/tb_divider_arbiter.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/divider_arbiter.sv
// Round-robin front end that shares one iterative divider among NUM_REQ requesters.
// One division is in flight at a time. A zero divisor is answered without starting the divider, and a hung divider is aborted after TIMEOUT cycles.
module divider_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 128
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic [NUM_REQ-1:0]       req_valid_in,
    input  logic [NUM_REQ*WIDTH-1:0] req_dividend_in,
    input  logic [NUM_REQ*WIDTH-1:0] req_divisor_in,
    output logic [NUM_REQ-1:0]       req_ready_out,
    output logic [NUM_REQ-1:0]       resp_valid_out,
    output logic [WIDTH-1:0]         resp_quotient_out,
    output logic [WIDTH-1:0]         resp_remainder_out,
    output logic                     resp_error_out,
    output logic [WIDTH-1:0]         div_dividend_out,
    output logic [WIDTH-1:0]         div_divisor_out,
    output logic                     div_start_out,
    input  logic [WIDTH-1:0]         div_quotient_in,
    input  logic [WIDTH-1:0]         div_remainder_in,
    input  logic                     div_done_in,
    input  logic                     div_error_in,
    input  logic                     div_busy_in
);
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DELIVER} state_t;

    state_t             state_q, state_d;
    logic [GW-1:0]      last_grant_q, last_grant_d;
    logic [NUM_REQ-1:0] ready_q, ready_d;
    logic [NUM_REQ-1:0] resp_valid_q, resp_valid_d;
    logic [WIDTH-1:0]   quotient_q, quotient_d;
    logic [WIDTH-1:0]   remainder_q, remainder_d;
    logic               error_q, error_d;
    logic [WIDTH-1:0]   dividend_q, dividend_d;
    logic [WIDTH-1:0]   divisor_q, divisor_d;
    logic               start_q, start_d;
    logic [TW-1:0]      timer_q, timer_d;

    logic [GW:0]        cand;
    logic               grant_found;
    logic [GW-1:0]      grant_idx;
    logic [WIDTH-1:0]   sel_dividend;
    logic [WIDTH-1:0]   sel_divisor;

    // Round-robin search starting one past the last winner, wrapping at NUM_REQ
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = {1'b0, last_grant_q} + (GW+1)'(i);
            if (cand >= (GW+1)'(NUM_REQ)) begin
                cand = cand - (GW+1)'(NUM_REQ);
            end
            if (!grant_found && req_valid_in[cand[GW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[GW-1:0];
            end
        end
        sel_dividend = req_dividend_in[int'(grant_idx)*WIDTH +: WIDTH];
        sel_divisor  = req_divisor_in[int'(grant_idx)*WIDTH +: WIDTH];
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        ready_d      = '0;
        resp_valid_d = '0;
        quotient_d   = quotient_q;
        remainder_d  = remainder_q;
        error_d      = error_q;
        dividend_d   = dividend_q;
        divisor_d    = divisor_q;
        start_d      = 1'b0;
        timer_d      = timer_q;
        case (state_q)
            IDLE: begin
                if (grant_found) begin
                    last_grant_d       = grant_idx;
                    ready_d[grant_idx] = 1'b1;
                    dividend_d         = sel_dividend;
                    divisor_d          = sel_divisor;
                    if (sel_divisor == '0) begin
                        quotient_d  = '0;
                        remainder_d = '0;
                        error_d     = 1'b1;
                        state_d     = DELIVER;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (!div_busy_in) begin
                    start_d = 1'b1;
                    timer_d = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // A completion in the same cycle as the timeout still wins
                if (div_done_in) begin
                    quotient_d  = div_quotient_in;
                    remainder_d = div_remainder_in;
                    error_d     = div_error_in;
                    state_d     = DELIVER;
                end else if (timer_q >= TW'(TIMEOUT - 1)) begin
                    quotient_d  = '0;
                    remainder_d = '0;
                    error_d     = 1'b1;
                    state_d     = DELIVER;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            DELIVER: begin
                resp_valid_d[last_grant_q] = 1'b1;
                state_d                    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q      <= IDLE;
            last_grant_q <= GW'(NUM_REQ - 1);
            ready_q      <= '0;
            resp_valid_q <= '0;
            quotient_q   <= '0;
            remainder_q  <= '0;
            error_q      <= 1'b0;
            dividend_q   <= '0;
            divisor_q    <= '0;
            start_q      <= 1'b0;
            timer_q      <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            ready_q      <= ready_d;
            resp_valid_q <= resp_valid_d;
            quotient_q   <= quotient_d;
            remainder_q  <= remainder_d;
            error_q      <= error_d;
            dividend_q   <= dividend_d;
            divisor_q    <= divisor_d;
            start_q      <= start_d;
            timer_q      <= timer_d;
        end
    end

    assign req_ready_out      = ready_q;
    assign resp_valid_out     = resp_valid_q;
    assign resp_quotient_out  = quotient_q;
    assign resp_remainder_out = remainder_q;
    assign resp_error_out     = error_q;
    assign div_dividend_out   = dividend_q;
    assign div_divisor_out    = divisor_q;
    assign div_start_out      = start_q;

endmodule

// File: tb/tb_divider_arbiter.sv
// Bench for divider_arbiter: a behavioural divider model, a round-robin reference,
// a constant vector table, randomized traffic and hand-written timeout/busy/reset sequences.
module tb_divider_arbiter;
    localparam int NUM_REQ = 4;
    localparam int WIDTH   = 32;
    localparam int TIMEOUT = 128;

    logic                     clk_in = 1'b0;
    logic                     rst_in;
    logic [NUM_REQ-1:0]       req_valid_in;
    logic [NUM_REQ*WIDTH-1:0] req_dividend_in;
    logic [NUM_REQ*WIDTH-1:0] req_divisor_in;
    logic [NUM_REQ-1:0]       req_ready_out;
    logic [NUM_REQ-1:0]       resp_valid_out;
    logic [WIDTH-1:0]         resp_quotient_out;
    logic [WIDTH-1:0]         resp_remainder_out;
    logic                     resp_error_out;
    logic [WIDTH-1:0]         div_dividend_out;
    logic [WIDTH-1:0]         div_divisor_out;
    logic                     div_start_out;
    logic [WIDTH-1:0]         div_quotient_in;
    logic [WIDTH-1:0]         div_remainder_in;
    logic                     div_done_in;
    logic                     div_error_in;
    logic                     div_busy_in;

    logic             model_busy, model_done, model_err;
    logic [WIDTH-1:0] model_q, model_r;
    int               model_cnt;
    int               div_lat;
    logic             never_done, err_mode, force_busy, inject_done;

    int checks = 0;
    int errors = 0;
    int model_last;

    typedef struct {
        int         idx;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic       err;
    } vec_t;
    vec_t vecs[8];

    divider_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .req_valid_in(req_valid_in), .req_dividend_in(req_dividend_in),
        .req_divisor_in(req_divisor_in), .req_ready_out(req_ready_out),
        .resp_valid_out(resp_valid_out), .resp_quotient_out(resp_quotient_out),
        .resp_remainder_out(resp_remainder_out), .resp_error_out(resp_error_out),
        .div_dividend_out(div_dividend_out), .div_divisor_out(div_divisor_out),
        .div_start_out(div_start_out), .div_quotient_in(div_quotient_in),
        .div_remainder_in(div_remainder_in), .div_done_in(div_done_in),
        .div_error_in(div_error_in), .div_busy_in(div_busy_in)
    );

    always #5 clk_in = ~clk_in;

    assign div_busy_in      = model_busy | force_busy;
    assign div_done_in      = model_done | inject_done;
    assign div_quotient_in  = model_q;
    assign div_remainder_in = model_r;
    assign div_error_in     = model_err;

    // Iterative divider stand-in with programmable latency, hang and error modes
    always @(posedge clk_in) begin
        if (rst_in) begin
            model_busy <= 1'b0;
            model_done <= 1'b0;
            model_err  <= 1'b0;
            model_q    <= '0;
            model_r    <= '0;
            model_cnt  <= 0;
        end else begin
            model_done <= 1'b0;
            if (!model_busy && div_start_out) begin
                model_busy <= 1'b1;
                model_cnt  <= div_lat;
                model_q    <= (div_divisor_out == 0) ? '0 : div_dividend_out / div_divisor_out;
                model_r    <= (div_divisor_out == 0) ? '0 : div_dividend_out % div_divisor_out;
            end else if (model_busy) begin
                if (model_cnt == 0) begin
                    model_busy <= 1'b0;
                    model_done <= !never_done;
                    model_err  <= err_mode;
                end else begin
                    model_cnt <= model_cnt - 1;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got hang expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    function automatic int oneHotIdx(input logic [NUM_REQ-1:0] v);
        if (!$onehot(v)) return -2;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    // Reference round-robin: first requester after the previous winner, wrapping
    function automatic int rrPick(input int last, input logic [NUM_REQ-1:0] mask);
        for (int i = 1; i <= NUM_REQ; i++) begin
            if (mask[(last + i) % NUM_REQ]) return (last + i) % NUM_REQ;
        end
        return -1;
    endfunction

    task automatic setOperands(input int i, input logic [31:0] a, input logic [31:0] b);
        req_dividend_in[i*WIDTH +: WIDTH] = a;
        req_divisor_in[i*WIDTH +: WIDTH]  = b;
    endtask

    task automatic waitReady(output int idx);
        idx = -1;
        for (int c = 0; c < 50 && idx == -1; c++) begin
            tick();
            if (req_ready_out != 0) idx = oneHotIdx(req_ready_out);
        end
    endtask

    task automatic waitResp(output int idx, output logic [31:0] q, output logic [31:0] r,
                            output logic err, output int resp_cyc, output int first_start,
                            output int starts);
        idx = -1; q = '0; r = '0; err = 1'b0; resp_cyc = -1; first_start = -1; starts = 0;
        for (int c = 1; c <= 400 && resp_cyc < 0; c++) begin
            tick();
            if (div_start_out) begin
                starts++;
                if (first_start < 0) first_start = c;
            end
            if (resp_valid_out != 0) begin
                idx = oneHotIdx(resp_valid_out);
                q = resp_quotient_out;
                r = resp_remainder_out;
                err = resp_error_out;
                resp_cyc = c;
            end
        end
        checkOutput("resp_arrived", longint'(resp_cyc > 0), 1);
    endtask

    task automatic applyStimulus(input int i, input logic [31:0] a, input logic [31:0] b,
                                 output int idx);
        setOperands(i, a, b);
        req_valid_in[i] = 1'b1;
        waitReady(idx);
        req_valid_in[i] = 1'b0;
    endtask

    task automatic checkResult(input string tag, input int idx, input logic [31:0] q,
                               input logic [31:0] r, input logic err, input int exp_idx,
                               input logic [31:0] a, input logic [31:0] b);
        checkOutput({tag, "_idx"}, idx, exp_idx);
        checkOutput({tag, "_q"}, q, (b == 0) ? 0 : a / b);
        checkOutput({tag, "_r"}, r, (b == 0) ? 0 : a % b);
        checkOutput({tag, "_err"}, err, (b == 0) ? 1 : 0);
    endtask

    initial begin
        int idx, exp, rc, fs, st, cnt;
        logic [31:0] q, r;
        logic err;
        logic [NUM_REQ-1:0] pend;
        logic [31:0] opa[NUM_REQ];
        logic [31:0] opb[NUM_REQ];

        vecs[0] = '{0, 32'd1000, 32'd40, 32'd25, 32'd0, 1'b0};
        vecs[1] = '{1, 32'd7, 32'd2, 32'd3, 32'd1, 1'b0};
        vecs[2] = '{2, 32'd5, 32'd0, 32'd0, 32'd0, 1'b1};
        vecs[3] = '{3, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0};
        vecs[4] = '{0, 32'd3, 32'd10, 32'd0, 32'd3, 1'b0};
        vecs[5] = '{1, 32'd0, 32'd5, 32'd0, 32'd0, 1'b0};
        vecs[6] = '{3, 32'd100, 32'd0, 32'd0, 32'd0, 1'b1};
        vecs[7] = '{2, 32'd123456, 32'd789, 32'd156, 32'd372, 1'b0};

        rst_in = 1'b1;
        req_valid_in = '0;
        req_dividend_in = '0;
        req_divisor_in = '0;
        div_lat = 3;
        never_done = 1'b0;
        err_mode = 1'b0;
        force_busy = 1'b0;
        inject_done = 1'b0;
        model_last = NUM_REQ - 1;
        repeat (3) tick();
        checkOutput("reset_ready", req_ready_out, 0);
        checkOutput("reset_resp_valid", resp_valid_out, 0);
        checkOutput("reset_start", div_start_out, 0);
        checkOutput("reset_quotient", resp_quotient_out, 0);
        checkOutput("reset_error", resp_error_out, 0);
        checkOutput("reset_div_dividend", div_dividend_out, 0);
        rst_in = 1'b0;
        tick();

        // All requesters held high: grants rotate 0,1,2,3,0
        for (int i = 0; i < NUM_REQ; i++) setOperands(i, 100 + i * 10, i + 2);
        req_valid_in = '1;
        for (int n = 0; n < 5; n++) begin
            exp = rrPick(model_last, 4'hF);
            waitReady(idx);
            checkOutput("rr_grant", idx, exp);
            model_last = exp;
            if (n == 4) req_valid_in = '0;
            waitResp(idx, q, r, err, rc, fs, st);
            checkResult("rr", idx, q, r, err, exp, 100 + exp * 10, exp + 2);
        end

        // Constant vector table, including zero-divisor short circuit and latencies
        for (int v = 0; v < 8; v++) begin
            applyStimulus(vecs[v].idx, vecs[v].a, vecs[v].b, idx);
            checkOutput("tbl_ready", idx, vecs[v].idx);
            model_last = vecs[v].idx;
            waitResp(idx, q, r, err, rc, fs, st);
            checkOutput("tbl_resp_idx", idx, vecs[v].idx);
            checkOutput("tbl_q", q, vecs[v].q);
            checkOutput("tbl_r", r, vecs[v].r);
            checkOutput("tbl_err", err, vecs[v].err);
            checkOutput("tbl_starts", st, vecs[v].err ? 0 : 1);
            if (vecs[v].err) checkOutput("tbl_zero_latency", rc, 1);
            else             checkOutput("tbl_start_latency", fs, 1);
        end

        // Randomized traffic against the round-robin and arithmetic reference
        pend = '0;
        for (int t = 0; t < 40; t++) begin
            div_lat = $urandom_range(0, 5);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    opa[i] = $urandom;
                    opb[i] = ($urandom_range(0, 6) == 0) ? 32'd0 :
                             ($urandom_range(0, 1) == 1) ? 32'($urandom_range(1, 20)) : $urandom;
                    setOperands(i, opa[i], opb[i]);
                    pend[i] = 1'b1;
                end
            end
            if (pend == 0) begin
                opa[1] = $urandom;
                opb[1] = 32'($urandom_range(1, 9));
                setOperands(1, opa[1], opb[1]);
                pend[1] = 1'b1;
            end
            req_valid_in = pend;
            exp = rrPick(model_last, pend);
            waitReady(idx);
            checkOutput("rand_grant", idx, exp);
            model_last = exp;
            pend[exp] = 1'b0;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (i != exp && !pend[i] && $urandom_range(0, 3) == 0) begin
                    opa[i] = $urandom;
                    opb[i] = 32'($urandom_range(0, 15));
                    setOperands(i, opa[i], opb[i]);
                    pend[i] = 1'b1;
                end
            end
            req_valid_in = pend;
            waitResp(idx, q, r, err, rc, fs, st);
            checkResult("rand", idx, q, r, err, exp, opa[exp], opb[exp]);
        end
        pend = '0;
        req_valid_in = '0;
        tick();

        // Divider never completes: abort after TIMEOUT cycles, late done ignored
        never_done = 1'b1;
        div_lat = 2;
        applyStimulus(1, 32'd100, 32'd3, idx);
        checkOutput("to_ready", idx, 1);
        model_last = 1;
        waitResp(idx, q, r, err, rc, fs, st);
        checkOutput("to_idx", idx, 1);
        checkOutput("to_err", err, 1);
        checkOutput("to_q", q, 0);
        checkOutput("to_r", r, 0);
        checkOutput("to_window", longint'((rc - fs) >= TIMEOUT && (rc - fs) <= TIMEOUT + 2), 1);
        inject_done = 1'b1;
        tick();
        inject_done = 1'b0;
        cnt = 0;
        repeat (6) begin
            tick();
            if (resp_valid_out != 0) cnt++;
        end
        checkOutput("late_done_ignored", cnt, 0);
        never_done = 1'b0;

        // Divider flags an error: result captured with err set
        err_mode = 1'b1;
        applyStimulus(0, 32'd50, 32'd7, idx);
        model_last = 0;
        waitResp(idx, q, r, err, rc, fs, st);
        checkOutput("derr_q", q, 7);
        checkOutput("derr_r", r, 1);
        checkOutput("derr_err", err, 1);
        err_mode = 1'b0;

        // Divider busy at grant: start held off until busy falls
        force_busy = 1'b1;
        applyStimulus(3, 32'd1000, 32'd40, idx);
        checkOutput("busy_ready", idx, 3);
        model_last = 3;
        cnt = 0;
        repeat (10) begin
            tick();
            if (div_start_out) cnt++;
        end
        checkOutput("busy_no_start", cnt, 0);
        force_busy = 1'b0;
        waitResp(idx, q, r, err, rc, fs, st);
        checkOutput("busy_start_latency", fs, 1);
        checkResult("busy", idx, q, r, err, 3, 32'd1000, 32'd40);

        // Reset during WAIT aborts the transaction and restarts arbitration at 0
        div_lat = 50;
        applyStimulus(2, 32'd500, 32'd5, idx);
        checkOutput("rst_ready", idx, 2);
        repeat (4) tick();
        rst_in = 1'b1;
        tick();
        checkOutput("rst_ready_zero", req_ready_out, 0);
        checkOutput("rst_resp_zero", resp_valid_out, 0);
        checkOutput("rst_start_zero", div_start_out, 0);
        checkOutput("rst_q_zero", resp_quotient_out, 0);
        checkOutput("rst_dividend_zero", div_dividend_out, 0);
        checkOutput("rst_divisor_zero", div_divisor_out, 0);
        rst_in = 1'b0;
        model_last = NUM_REQ - 1;
        cnt = 0;
        repeat (60) begin
            tick();
            if (resp_valid_out != 0) cnt++;
        end
        checkOutput("rst_no_resp", cnt, 0);
        div_lat = 2;
        for (int i = 0; i < NUM_REQ; i++) setOperands(i, 90 + i, 4);
        req_valid_in = '1;
        exp = rrPick(model_last, 4'hF);
        waitReady(idx);
        checkOutput("rst_first_grant", idx, exp);
        req_valid_in = '0;
        waitResp(idx, q, r, err, rc, fs, st);
        checkResult("rst_after", idx, q, r, err, exp, 90 + exp, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
